// File: rtl/divider_pkg.sv
// Shared core package: ALU and divider operation encodings plus small decode helpers.
package divider_pkg;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra
  } aluOp_t;

  // Encoding matches the low two funct3 bits of the RV32M divide group.
  typedef enum logic [1:0] {
    OpDiv, OpDivu, OpRem, OpRemu
  } divOp_t;

  function automatic logic op_is_signed(divOp_t o);
    return (o == OpDiv) || (o == OpRem);
  endfunction

  function automatic logic op_is_rem(divOp_t o);
    return (o == OpRem) || (o == OpRemu);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0]   rem_in,
  input  logic [Width-1:0] div_b,
  input  logic             next_bit,
  output logic [Width:0]   rem_out,
  output logic             q_bit
);

  logic [Width+1:0] shifted;
  logic [Width+1:0] diff;

  always_comb begin
    shifted = {rem_in, next_bit};
    diff    = shifted - {2'b00, div_b};
    q_bit   = ~diff[Width+1];
    rem_out = q_bit ? diff[Width:0] : shifted[Width:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; fixed Width+2 cycle latency.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  divOp_t           op,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result
);

  localparam int unsigned CntW = $clog2(Width);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StIter = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  logic [1:0]      state_q, state_d;
  divOp_t          op_q, op_d;
  logic [Width-1:0] aq_q, aq_d;  // dividend magnitude, shifted out as quotient shifts in
  logic [Width-1:0] b_q, b_d;
  logic [Width:0]   r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [Width-1:0] result_q, result_d;

  logic [Width:0]   step_r;
  logic             step_q;
  logic             sign_a, sign_b;
  logic [Width-1:0] q_fin, r_fin;

  div_step #(
    .Width(Width)
  ) u_step (
    .rem_in  (r_q),
    .div_b   (b_q),
    .next_bit(aq_q[Width-1]),
    .rem_out (step_r),
    .q_bit   (step_q)
  );

  assign sign_a = op_is_signed(op_q) & aq_q[Width-1];
  assign sign_b = op_is_signed(op_q) & b_q[Width-1];
  assign q_fin  = {aq_q[Width-2:0], step_q};
  assign r_fin  = step_r[Width-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    aq_d     = aq_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    case (state_q)
      // The done cycle (StFix) is also the first idle cycle, so it accepts start.
      StIdle, StFix: begin
        state_d = StIdle;
        if (start) begin
          state_d = StPrep;
          op_d    = op;
          aq_d    = dividend;
          b_d     = divisor;
        end
      end
      StPrep: begin
        aq_d    = sign_a ? -aq_q : aq_q;
        b_d     = sign_b ? -b_q : b_q;
        q_neg_d = (sign_a ^ sign_b) & (b_q != '0);
        r_neg_d = sign_a;
        r_d     = '0;
        cnt_d   = CntW'(Width - 1);
        state_d = StIter;
      end
      StIter: begin
        r_d   = step_r;
        aq_d  = q_fin;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
          // Sign fix-up folded into the last step so result is ready with done.
          if (op_is_rem(op_q)) result_d = r_neg_q ? -r_fin : r_fin;
          else                 result_d = q_neg_q ? -q_fin : q_fin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      aq_q     <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      aq_q     <= aq_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == StPrep) || (state_q == StIter);
  assign done   = (state_q == StFix);
  assign result = result_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: driver queues expected results, a monitor checks them on done.
module tb_divider;
  import divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  divOp_t      op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];

  divider #(
    .Width(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h at cycle %0d expected no done", result, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, cyc, e.at);
        check({e.name, "_busy_on_done"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; drives start for one cycle and returns at the next negedge.
  task automatic issue(input string name, input divOp_t o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input bit accept);
    exp_t e;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    if (accept) begin
      e.res  = want;
      e.at   = cyc + 34;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input divOp_t o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] want);
    issue(name, o, a, b, want, 1'b1);
    wait_drain();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = OpDiv;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with an ignored start pulsed 5 cycles in.
    issue("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (4) @(negedge clk);
    check("busy_mid", {31'b0, busy}, 32'd1);
    issue("ignored_9_3", OpDivu, 32'd9, 32'd3, 32'd3, 1'b0);
    wait_drain();

    run("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2);
    run("div_m7_2",   OpDiv,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_m7_2",   OpRem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("div_7_m2",   OpDiv,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run("rem_7_m2",   OpRem,  32'd7, 32'hFFFF_FFFE, 32'd1);
    run("divu_5_0",   OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("div_m5_0",   OpDiv,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run("rem_m5_0",   OpRem,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("remu_5_0",   OpRemu, 32'd5, 32'd0, 32'd5);
    run("div_ovf",    OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",    OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("divu_max_10", OpDivu, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999);
    run("remu_max_10", OpRemu, 32'hFFFF_FFFF, 32'd10, 32'd5);

    // Back-to-back: second start lands on the first one's done cycle.
    issue("b2b_first", OpDivu, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (33) @(negedge clk);
    issue("b2b_10_5", OpDivu, 32'd10, 32'd5, 32'd2, 1'b1);
    wait_drain();

    // Reset 10 cycles into an operation: no done may follow.
    issue("aborted", OpDivu, 32'd77, 32'd3, 32'd25, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run("after_reset", OpDivu, 32'd100, 32'd7, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
